fc_classify_decision: RTL and testbench

FC_CLASSIFY_DECISION -- requirements
Module: fc_classify_decision

---
 rtl/fc_classify_decision.sv | 102 ++++++++++
 tb/tb_fc_classify_decision.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fc_classify_decision.sv
// Two-class FP32 argmax decision stage with result hold/ack handshake and frame/drop counters.
// Optional FC_CLASSIFY_THRESHOLD_EN: class 1 must also exceed THRESHOLD to win.
module fc_classify_decision #(
  parameter logic [31:0] THRESHOLD = 32'h00000000,
  parameter int          DROP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       class0,
  input  logic [31:0]       class1,
  input  logic              ack_in,
  output logic              valid_out,
  output logic              class_id,
  output logic [31:0]       max_score,
  output logic              nan_flag,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, CMP, RESULT} state_t;

  // -0.0 is folded onto +0.0 so the two zeros share one key.
  function automatic logic [31:0] order_key(input logic [31:0] f);
    logic [31:0] n;
    n = (f[30:0] == 31'd0) ? 32'd0 : f;
    return n[31] ? ~n : {1'b1, n[30:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         c0_q, c1_q;
  logic                class_id_q, nan_q;
  logic [31:0]         max_q;
  logic [15:0]         frame_q;
  logic [DROP_W-1:0]   drop_q;
  logic                accept, drop, nan_c, win1;

  assign accept = valid_in && (state_q == IDLE || (state_q == RESULT && ack_in));
  assign drop   = valid_in && (state_q == CMP  || (state_q == RESULT && !ack_in));

  always_comb begin
    nan_c = is_nan(c0_q) || is_nan(c1_q);
`ifdef FC_CLASSIFY_THRESHOLD_EN
    win1  = !nan_c && (order_key(c1_q) > order_key(c0_q))
                   && (order_key(c1_q) > order_key(THRESHOLD));
`else
    win1  = !nan_c && (order_key(c1_q) > order_key(c0_q));
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = CMP;
      CMP:     state_d = RESULT;
      RESULT:  if (ack_in) state_d = valid_in ? CMP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      c0_q       <= '0;
      c1_q       <= '0;
      class_id_q <= 1'b0;
      nan_q      <= 1'b0;
      max_q      <= '0;
      frame_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        c0_q    <= class0;
        c1_q    <= class1;
        frame_q <= frame_q + 16'd1;
      end
      // Saturating drop counter: holds at all-ones.
      if (drop && drop_q != {DROP_W{1'b1}})
        drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
      if (state_q == CMP) begin
        class_id_q <= win1;
        nan_q      <= nan_c;
        max_q      <= win1 ? c1_q : c0_q;
      end
    end
  end

  assign valid_out   = (state_q == RESULT);
  assign busy        = (state_q != IDLE);
  assign class_id    = class_id_q;
  assign max_score   = max_q;
  assign nan_flag    = nan_q;
  assign frame_count = frame_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_fc_classify_decision.sv
// Directed bench for fc_classify_decision: default instance plus a DROP_W=2 / THRESHOLD=3.0 instance.
module tb_fc_classify_decision;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_reset = 1'b1, a_valid = 1'b0, a_ack = 1'b0;
  logic [31:0] a_c0 = '0, a_c1 = '0;
  logic        a_vo, a_id, a_nan, a_busy;
  logic [31:0] a_max;
  logic [15:0] a_fc;
  logic [7:0]  a_dc;

  // Instance B: DROP_W=2, THRESHOLD=3.0
  logic        b_reset = 1'b1, b_valid = 1'b0, b_ack = 1'b0;
  logic [31:0] b_c0 = '0, b_c1 = '0;
  logic        b_vo, b_id, b_nan, b_busy;
  logic [31:0] b_max;
  logic [15:0] b_fc;
  logic [1:0]  b_dc;

  int checks = 0;
  int errors = 0;

  fc_classify_decision dut_a (
    .clk(clk), .reset(a_reset), .valid_in(a_valid), .class0(a_c0), .class1(a_c1),
    .ack_in(a_ack), .valid_out(a_vo), .class_id(a_id), .max_score(a_max),
    .nan_flag(a_nan), .busy(a_busy), .frame_count(a_fc), .drop_count(a_dc)
  );

  fc_classify_decision #(.THRESHOLD(32'h40400000), .DROP_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .valid_in(b_valid), .class0(b_c0), .class1(b_c1),
    .ack_in(b_ack), .valid_out(b_vo), .class_id(b_id), .max_score(b_max),
    .nan_flag(b_nan), .busy(b_busy), .frame_count(b_fc), .drop_count(b_dc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full frame from IDLE on instance A, checked two edges after the pulse, then acked.
  task automatic frame_a(input string tag, input logic [31:0] c0, input logic [31:0] c1,
                         input logic exp_id, input logic [31:0] exp_max, input logic exp_nan,
                         input logic [15:0] exp_fc);
    a_c0 = c0; a_c1 = c1; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    tick;
    tick;
    check({tag, "_vo"},  32'(a_vo),  32'd1);
    check({tag, "_id"},  32'(a_id),  32'(exp_id));
    check({tag, "_max"}, a_max,      exp_max);
    check({tag, "_nan"}, 32'(a_nan), 32'(exp_nan));
    check({tag, "_fc"},  32'(a_fc),  32'(exp_fc));
    a_ack = 1'b1;
    tick;
    a_ack = 1'b0;
    check({tag, "_idle"}, 32'(a_busy), 32'd0);
  endtask

  initial begin
    tick; tick;
    a_reset = 1'b0;
    check("rst_vo",   32'(a_vo),   32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_id",   32'(a_id),   32'd0);
    check("rst_nan",  32'(a_nan),  32'd0);
    check("rst_max",  a_max,       32'd0);
    check("rst_fc",   32'(a_fc),   32'd0);
    check("rst_dc",   32'(a_dc),   32'd0);

    // 1.0 vs 2.0: pulse at edge N
    a_c0 = 32'h3F800000; a_c1 = 32'h40000000; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    check("f1_cmp_busy", 32'(a_busy), 32'd1);
    check("f1_cmp_vo",   32'(a_vo),   32'd0);
    tick;
    tick;
    check("f1_vo",  32'(a_vo), 32'd1);
    check("f1_id",  32'(a_id), 32'd1);
    check("f1_max", a_max,     32'h40000000);
    check("f1_fc",  32'(a_fc), 32'd1);

    // three drops while RESULT is held without ack
    for (int i = 0; i < 3; i++) begin
      a_c0 = 32'h12345678; a_c1 = 32'h7F000000; a_valid = 1'b1;
      tick;
      a_valid = 1'b0;
      tick;
    end
    check("drop_dc",  32'(a_dc), 32'd3);
    check("drop_vo",  32'(a_vo), 32'd1);
    check("drop_id",  32'(a_id), 32'd1);
    check("drop_max", a_max,     32'h40000000);
    check("drop_fc",  32'(a_fc), 32'd1);

    // ack together with valid: -0.0 vs +0.0 accepted straight into CMP
    a_c0 = 32'h80000000; a_c1 = 32'h00000000; a_valid = 1'b1; a_ack = 1'b1;
    tick;
    a_valid = 1'b0; a_ack = 1'b0;
    check("bb_busy", 32'(a_busy), 32'd1);
    check("bb_vo",   32'(a_vo),   32'd0);
    check("bb_fc",   32'(a_fc),   32'd2);
    check("bb_dc",   32'(a_dc),   32'd3);
    tick;
    check("zero_vo",  32'(a_vo),  32'd1);
    check("zero_id",  32'(a_id),  32'd0);
    check("zero_max", a_max,      32'h80000000);
    check("zero_nan", 32'(a_nan), 32'd0);
    a_ack = 1'b1;
    tick;
    a_ack = 1'b0;
    check("ack_idle", 32'(a_busy), 32'd0);

    frame_a("nan0",  32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 16'd3);
    frame_a("inf",   32'hFF800000, 32'h7F800000, 1'b1, 32'h7F800000, 1'b0, 16'd4);
    frame_a("neg",   32'hBF800000, 32'hC0000000, 1'b0, 32'hBF800000, 1'b0, 16'd5);
    frame_a("tie",   32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 1'b0, 16'd6);
    frame_a("nan1",  32'h3F800000, 32'h7F800001, 1'b0, 32'h3F800000, 1'b1, 16'd7);
    frame_a("mixed", 32'hC0000000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0, 16'd8);
    check("a_dc_end", 32'(a_dc), 32'd3);

    // reset with valid_in in the same cycle
    a_reset = 1'b1; a_valid = 1'b1; a_c0 = 32'h3F800000; a_c1 = 32'h40000000;
    tick;
    a_reset = 1'b0; a_valid = 1'b0;
    check("rstv_busy", 32'(a_busy), 32'd0);
    check("rstv_fc",   32'(a_fc),   32'd0);
    check("rstv_dc",   32'(a_dc),   32'd0);
    tick;
    check("rstv_busy2", 32'(a_busy), 32'd0);

    // Instance B: threshold decision, drop saturation, reset mid-CMP
    b_reset = 1'b0;
    b_c0 = 32'h3F800000; b_c1 = 32'h40000000; b_valid = 1'b1;
    tick;
    b_valid = 1'b0;
    tick;
    tick;
    check("thr_vo", 32'(b_vo), 32'd1);
`ifdef FC_CLASSIFY_THRESHOLD_EN
    check("thr_id",  32'(b_id), 32'd0);
    check("thr_max", b_max,     32'h3F800000);
`else
    check("thr_id",  32'(b_id), 32'd1);
    check("thr_max", b_max,     32'h40000000);
`endif
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1;
      tick;
      b_valid = 1'b0;
      tick;
    end
    check("sat_dc", 32'(b_dc), 32'd3);
    b_valid = 1'b1; b_ack = 1'b1;
    tick;
    b_valid = 1'b0; b_ack = 1'b0;
    check("b_cmp_busy", 32'(b_busy), 32'd1);
    check("b_cmp_fc",   32'(b_fc),   32'd2);
    b_reset = 1'b1;
    tick;
    b_reset = 1'b0;
    check("b_rst_vo",   32'(b_vo),   32'd0);
    check("b_rst_busy", 32'(b_busy), 32'd0);
    check("b_rst_fc",   32'(b_fc),   32'd0);
    check("b_rst_dc",   32'(b_dc),   32'd0);
    tick;
    check("b_rst_vo2",  32'(b_vo),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
